// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants for the memory/write-back boundary.
package mips_pkg;

  localparam logic [1:0] LD_WORD  = 2'b00;
  localparam logic [1:0] LD_HALF  = 2'b01;
  localparam logic [1:0] LD_BYTE  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Everything the write-back stage sees from the MEM/WB register.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] mem;
    logic [31:0] alu;
    logic        isLd;
    logic        isCall;
    logic [4:0]  rd;
    logic        regwrite;
    logic        misalign;
    logic        flag_err;
  } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// Big-endian load formatter: lane select by byte offset, sign/zero extension,
// and alignment check. Purely combinational.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  b;
  logic [15:0] h;

  // Pick the addressed byte/half (offset 0 is the most significant lane)
  // then extend; the reserved size code behaves as a word load.
  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    case (off)
      2'd0:    b = raw[31:24];
      2'd1:    b = raw[23:16];
      2'd2:    b = raw[15:8];
      default: b = raw[7:0];
    endcase
    h = off[1] ? raw[15:0] : raw[31:16];
    case (size)
      LD_BYTE: data = {{24{~ld_unsigned & b[7]}}, b};
      LD_HALF: begin
        data       = {{16{~ld_unsigned & h[15]}}, h};
        misaligned = off[0];
      end
      default: begin
        data       = raw;
        misaligned = (off != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures memory-stage results, formats load data,
// and qualifies the register-file write enable. One cycle, fully registered.
module mem_wb_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_mem_raw,
  input  logic [31:0] in_alu,
  input  logic [1:0]  in_ld_size,
  input  logic        in_ld_unsigned,
  input  logic        in_isLd,
  input  logic        in_isCall,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_mem,
  output logic [31:0] out_alu,
  output logic        out_isLd,
  output logic        out_isCall,
  output logic [4:0]  out_rd,
  output logic        out_regwrite,
  output logic        misalign,
  output logic        flag_err
);

  logic [31:0] ld_data;
  logic        ld_mis;
  mem_wb_t     nxt;
  mem_wb_t     r;

  load_align u_align (
    .raw         (in_mem_raw),
    .off         (in_alu[1:0]),
    .size        (in_ld_size),
    .ld_unsigned (in_ld_unsigned),
    .data        (ld_data),
    .misaligned  (ld_mis)
  );

  // Entry to capture: a bubble when nothing valid arrives, otherwise the
  // qualified fields. Illegal flag combos and misaligned loads never write.
  always_comb begin
    nxt = '0;
    if (in_valid) begin
      nxt.valid    = 1'b1;
      nxt.pc       = in_pc;
      nxt.alu      = in_alu;
      nxt.rd       = in_rd;
      nxt.misalign = in_isLd & ld_mis;
      nxt.flag_err = in_isLd & in_isCall;
      nxt.isLd     = in_isLd   & ~nxt.flag_err;
      nxt.isCall   = in_isCall & ~nxt.flag_err;
      nxt.mem      = (in_isLd & ~nxt.misalign) ? ld_data : 32'd0;
      nxt.regwrite = in_regwrite & (in_rd != REG_ZERO)
                   & ~nxt.misalign & ~nxt.flag_err;
    end
  end

  // Register update with priority rst > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst)        r <= '0;
    else if (flush) r <= '0;
    else if (!stall) r <= nxt;
  end

  assign out_valid    = r.valid;
  assign out_pc       = r.pc;
  assign out_mem      = r.mem;
  assign out_alu      = r.alu;
  assign out_isLd     = r.isLd;
  assign out_isCall   = r.isCall;
  assign out_rd       = r.rd;
  assign out_regwrite = r.regwrite;
  assign misalign     = r.misalign;
  assign flag_err     = r.flag_err;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register for the 5-stage MIPS core. Captures the memory-stage results each cycle, aligns and sign/zero-extends load data, and presents registered `isLd`/`isCall` flags, link PC, load data and ALU result to the write-back select mux and the register-file write port. Supports stall, flush and misaligned-load detection.

## Interface
- No parameters. Data width is fixed at 32 and register index width at 5.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold current contents.
- `flush` in 1: load a bubble.
- `in_valid` in 1: a memory-stage instruction is present.
- `in_pc` in 32: link address for calls, passed through unchanged.
- `in_mem_raw` in 32: raw word from data memory.
- `in_alu` in 32: ALU result. For loads, `in_alu[1:0]` is the byte offset.
- `in_ld_size` in 2: load size. 00 = word, 01 = half, 10 = byte, 11 = reserved, treated as word.
- `in_ld_unsigned` in 1: 1 = zero-extend, 0 = sign-extend.
- `in_isLd`, `in_isCall` in 1 each: write-back source flags.
- `in_rd` in 5: destination register.
- `in_regwrite` in 1: instruction writes `rd`.
- `out_valid` out 1.
- `out_pc`, `out_mem`, `out_alu` out 32 each. `out_mem` holds the aligned and extended load data.
- `out_isLd`, `out_isCall` out 1 each.
- `out_rd` out 5.
- `out_regwrite` out 1: final write enable.
- `misalign` out 1: the registered entry is a misaligned load.
- `flag_err` out 1: the registered entry had both flags set.

## Operation
- Priority on each rising `clk`: `rst` > `flush` > `stall` > capture.
- **rst:** all outputs go to 0.
- **flush:** load a bubble. `out_valid`, `out_regwrite`, `misalign`, `flag_err`, `out_isLd` and `out_isCall` go to 0. The data fields go to 0.
- **stall:** every output register holds its value.
- **capture:** register every input field. Load data is formatted as follows, big-endian, with `off = in_alu[1:0]`:
  - byte: `off` 0/1/2/3 selects bits [31:24]/[23:16]/[15:8]/[7:0].
  - half: `off[1]` 0/1 selects bits [31:16]/[15:0].
  - word: the full word.
  - Extension: sign- or zero-extend to 32 bits per `in_ld_unsigned`.
- **Misaligned load:** `in_isLd` set and either (half with `off[0]=1`) or (word with `off≠0`).
  - `misalign` = 1.
  - `out_mem` = 0.
- **Both flags set:** `in_isLd` and `in_isCall` both set is illegal.
  - `flag_err` = 1.
  - `out_isLd` = `out_isCall` = 0.
- **Write enable:** `out_regwrite` = `in_valid & in_regwrite & (in_rd≠0) & ~misalign & ~flag_err`, all evaluated at capture.
- **Invalid input (`in_valid`=0):** captured as a bubble, identical to flush.
- **Non-load entries:** `out_mem` = 0 when `in_isLd`=0.

## Timing
- Latency is exactly 1 cycle from input to output. There is no combinational path from any input to any output.
- `stall` held for N cycles leaves the outputs unchanged for N cycles. The capture on the first edge after `stall` deasserts uses the inputs present at that edge.
- `flush` and `stall` in the same cycle give a bubble.
- `rst` asserted mid-stream discards the held entry; the next cycle outputs all zeros. The first capture happens on the first edge with `rst` low.
- `misalign` and `flag_err` are level outputs for the registered entry. They are not one-cycle pulses: under a stall they stay asserted for as long as the entry is held.

## Structure
- Shared package `mips_pkg`:
  - `LD_WORD`, `LD_HALF`, `LD_BYTE` (2-bit constants).
  - `REG_ZERO` = 5'd0.
  - Typedef `mem_wb_t`, a struct of all output fields.
- Sub-module `load_align`: combinational. Inputs are raw word, offset, size and unsigned. Outputs are the formatted data and the misaligned flag. It is instantiated once, in front of the capture register.
- The top level holds only the priority register logic and the write-enable equation.

## Test plan
- **Reset and bubble:** `rst`=1 for 2 cycles, then `in_valid`=0 → all outputs 0.
- **Byte load, sign-extended:** `in_mem_raw`=0x12F45678, `in_alu`=0x1001, byte, signed, `rd`=8 → next cycle `out_mem`=0xFFFFFFF4, `out_regwrite`=1, `out_rd`=8.
- **Half load, zero-extended:** `in_mem_raw`=0x1234ABCD, `in_alu`=0x2002, half, unsigned → `out_mem`=0x0000ABCD.
- **Misaligned word load:** `in_alu`=0x3001, word → `misalign`=1, `out_regwrite`=0, `out_mem`=0.
- **Call with stall:** `in_isCall`=1, `in_pc`=0x00400010, `rd`=31 → captured. Then `stall`=1 for 3 cycles with changed inputs → outputs hold 0x00400010 / `out_rd`=31. Then `flush` together with `stall` → bubble.
- **Write suppression:**
  - `rd`=0 with regwrite → `out_regwrite`=0.
  - `in_isLd`=`in_isCall`=1 → `flag_err`=1, both flags 0, `out_regwrite`=0.
